// File: rtl/multi_breath_pwm_pkg.sv
// Shared types and helpers for the multi-channel breathing PWM.
// Channel modes, ramp direction and the per-channel stagger offset.
package multi_breath_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_CONST = 2'd1,
        MODE_SAW   = 2'd2,
        MODE_TRI   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Spreads channel compare points evenly over one PWM period.
    function automatic int unsigned stagger_offset(input int unsigned ch,
                                                   input int unsigned num_ch,
                                                   input int unsigned resolution);
        int unsigned levels;
        levels = 32'd1 << resolution;
        return (ch * (levels / num_ch)) % levels;
    endfunction

endpackage

// File: rtl/pwm_ramp_ch.sv
// One PWM channel: shadow config, ramp generator, period-aligned commit
// and registered compare against the (optionally offset) shared counter.
module pwm_ramp_ch
    import multi_breath_pwm_pkg::*;
#(
    parameter int          RESOLUTION = 8,
    parameter int unsigned OFFSET     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [1:0]            wr_mode,
    input  logic [RESOLUTION-1:0] wr_duty,
    input  logic                  step,
    input  logic                  boundary,
    input  logic [RESOLUTION-1:0] cnt,
    output logic                  pwm
);

    localparam logic [RESOLUTION-1:0] OFFSET_L = RESOLUTION'(OFFSET);

    mode_e                  shadow_mode_reg;
    logic [RESOLUTION-1:0]  shadow_duty_reg;
    logic [RESOLUTION-1:0]  ramp_reg;
    logic [RESOLUTION-1:0]  ramp_next;
    dir_e                   dir_reg;
    dir_e                   dir_next;
    mode_e                  active_mode_reg;
    logic [RESOLUTION-1:0]  active_duty_reg;
    logic                   pwm_reg;
    logic [RESOLUTION-1:0]  cnt_i;

    assign cnt_i = cnt + OFFSET_L;
    assign pwm   = pwm_reg;

    // A config write overrides a coincident ramp step.
    always_comb begin
        ramp_next = ramp_reg;
        dir_next  = dir_reg;
        if (wr) begin
            ramp_next = wr_duty;
            dir_next  = DIR_UP;
        end else if (step) begin
            case (shadow_mode_reg)
                MODE_SAW: ramp_next = ramp_reg + 1'b1;
                MODE_TRI: begin
                    if (dir_reg == DIR_UP) begin
                        if (ramp_reg == '1) dir_next = DIR_DOWN;
                        else                ramp_next = ramp_reg + 1'b1;
                    end else begin
                        if (ramp_reg == '0) dir_next = DIR_UP;
                        else                ramp_next = ramp_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_mode_reg <= MODE_OFF;
            shadow_duty_reg <= '0;
            ramp_reg        <= '0;
            dir_reg         <= DIR_UP;
            active_mode_reg <= MODE_OFF;
            active_duty_reg <= '0;
            pwm_reg         <= 1'b0;
        end else begin
            if (wr) begin
                shadow_mode_reg <= mode_e'(wr_mode);
                shadow_duty_reg <= wr_duty;
            end
            ramp_reg <= ramp_next;
            dir_reg  <= dir_next;
            // Commit sees pre-edge values, so a boundary-cycle write waits a period.
            if (boundary) begin
                active_mode_reg <= shadow_mode_reg;
                case (shadow_mode_reg)
                    MODE_OFF:   active_duty_reg <= '0;
                    MODE_CONST: active_duty_reg <= shadow_duty_reg;
                    default:    active_duty_reg <= ramp_reg;
                endcase
            end
            pwm_reg <= (active_mode_reg != MODE_OFF) && (cnt_i < active_duty_reg);
        end
    end

endmodule

// File: rtl/multi_breath_pwm.sv
// NUM_CH breathing PWM channels sharing prescaler, period counter and ramp timer.
// Define MULTI_BREATH_PWM_STAGGER_EN to phase-offset each channel's compare point.
module multi_breath_pwm
    import multi_breath_pwm_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RESOLUTION  = 8,
    parameter int DVSR        = 488,
    parameter int GRAD_THRESH = 250_000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [RESOLUTION-1:0] cfg_duty,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_start
);

    localparam int PRESC_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int GRAD_W  = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [PRESC_W-1:0]    presc_reg;
    logic [RESOLUTION-1:0] cnt_reg;
    logic [GRAD_W-1:0]     grad_reg;
    logic                  period_start_reg;
    logic                  tick;
    logic                  boundary;
    logic                  step;
    logic                  cfg_ch_valid;

    assign tick         = (presc_reg == PRESC_W'(DVSR - 1));
    assign boundary     = tick && (cnt_reg == '1);
    assign step         = (grad_reg == GRAD_W'(GRAD_THRESH - 1));
    assign cfg_ch_valid = ({1'b0, cfg_ch} < NUM_CH_L);
    assign period_start = period_start_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg        <= '0;
            cnt_reg          <= '0;
            grad_reg         <= '0;
            period_start_reg <= 1'b0;
        end else begin
            presc_reg        <= tick ? '0 : presc_reg + 1'b1;
            grad_reg         <= step ? '0 : grad_reg + 1'b1;
            period_start_reg <= boundary;
            if (tick) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef MULTI_BREATH_PWM_STAGGER_EN
            localparam int unsigned OFFSET = stagger_offset(gi, NUM_CH, RESOLUTION);
`else
            localparam int unsigned OFFSET = 0;
`endif
            logic ch_we;
            assign ch_we = cfg_we && cfg_ch_valid && (cfg_ch == CH_W'(gi));

            pwm_ramp_ch #(
                .RESOLUTION (RESOLUTION),
                .OFFSET     (OFFSET)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .wr       (ch_we),
                .wr_mode  (cfg_mode),
                .wr_duty  (cfg_duty),
                .step     (step),
                .boundary (boundary),
                .cnt      (cnt_reg),
                .pwm      (pwm_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_breath_pwm.sv
// Self-checking bench for multi_breath_pwm: table-driven duty checks, ramp and
// boundary sequences, plus random config traffic against a cycle reference model.
`timescale 1ns/1ps
module tb_multi_breath_pwm;

    localparam int NUM_CH = 3;
    localparam int R      = 4;
    localparam int LEVELS = 1 << R;
    localparam int DVSR   = 2;
    localparam int PERIOD = DVSR * LEVELS;
    localparam int G      = PERIOD;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [R-1:0]      cfg_duty;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_breath_pwm #(
        .NUM_CH      (NUM_CH),
        .RESOLUTION  (R),
        .DVSR        (DVSR),
        .GRAD_THRESH (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_duty     (cfg_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ch_offset(input int ch);
`ifdef MULTI_BREATH_PWM_STAGGER_EN
        return ch * (LEVELS / NUM_CH);
`else
        return 0 * ch;
`endif
    endfunction

    int m_k;
    int m_smode[NUM_CH];
    int m_sduty[NUM_CH];
    int m_ramp[NUM_CH];
    bit m_up[NUM_CH];
    int m_amode[NUM_CH];
    int m_aduty[NUM_CH];
    int m_cnt;
    bit m_bnd;
    bit m_stp;
    logic [NUM_CH-1:0] exp_pwm = '0;
    logic              exp_ps = 1'b0;

    // Time since reset determines every shared event; channels follow mode rules.
    always @(posedge clk) begin
        if (rst) begin
            m_k = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_smode[c] = 0; m_sduty[c] = 0; m_ramp[c] = 0; m_up[c] = 1'b1;
                m_amode[c] = 0; m_aduty[c] = 0;
            end
            exp_pwm = '0;
            exp_ps  = 1'b0;
        end else begin
            m_cnt = (m_k / DVSR) % LEVELS;
            m_bnd = (m_k % PERIOD) == PERIOD - 1;
            m_stp = (m_k % G) == G - 1;
            for (int c = 0; c < NUM_CH; c++)
                exp_pwm[c] = (m_amode[c] != 0) && (((m_cnt + ch_offset(c)) % LEVELS) < m_aduty[c]);
            exp_ps = m_bnd;
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_bnd) begin
                    m_amode[c] = m_smode[c];
                    m_aduty[c] = (m_smode[c] == 0) ? 0 : (m_smode[c] == 1) ? m_sduty[c] : m_ramp[c];
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_smode[c] = int'(cfg_mode);
                    m_sduty[c] = int'(cfg_duty);
                    m_ramp[c]  = int'(cfg_duty);
                    m_up[c]    = 1'b1;
                end else if (m_stp) begin
                    if (m_smode[c] == 2) begin
                        m_ramp[c] = (m_ramp[c] + 1) % LEVELS;
                    end else if (m_smode[c] == 3) begin
                        if (m_up[c]) begin
                            if (m_ramp[c] == LEVELS - 1) m_up[c] = 1'b0;
                            else                         m_ramp[c] = m_ramp[c] + 1;
                        end else begin
                            if (m_ramp[c] == 0) m_up[c] = 1'b1;
                            else                m_ramp[c] = m_ramp[c] - 1;
                        end
                    end
                end
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pwm_out", int'(pwm_out), int'(exp_pwm));
            check("model_period_start", int'(period_start), int'(exp_ps));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ps();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_ps: got no period_start expected one within %0d cycles", 4 * PERIOD);
        end
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = R'(duty);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // High-cycle count of one channel over n consecutive periods.
    task automatic measure(input int ch, input int n, input bit aligned, output int highs[24]);
        int h;
        for (int p = 0; p < 24; p++) highs[p] = -1;
        if (!aligned) wait_ps();
        for (int p = 0; p < n; p++) begin
            h = 0;
            for (int c = 0; c < PERIOD; c++) begin
                @(negedge clk);
                h += int'(pwm_out[ch]);
            end
            highs[p] = h;
        end
    endtask

    typedef struct {
        int ch;
        int mode;
        int duty;
        int exp_highs;
    } vec_t;

    vec_t tbl[6];
    int   hs[24];
    int   tri_exp[20];
    int   last_ps;
    int   n_ps;
    int   first_ps;
    int   acc;

    initial begin
        tbl[0] = '{0, 1, 5,  10};
        tbl[1] = '{1, 1, 0,  0};
        tbl[2] = '{2, 1, 15, 30};
        tbl[3] = '{1, 1, 8,  16};
        tbl[4] = '{2, 0, 9,  0};
        tbl[5] = '{0, 1, 1,  2};

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_start", int'(period_start), 0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Idle: period_start every PERIOD cycles, outputs low.
        last_ps = -1; n_ps = 0; first_ps = -1; acc = 0;
        for (int c = 0; c < 3 * PERIOD + 4; c++) begin
            @(negedge clk);
            acc += int'(pwm_out != '0);
            if (period_start) begin
                if (last_ps >= 0) check("idle_ps_interval", c - last_ps, PERIOD);
                else              first_ps = c;
                last_ps = c;
                n_ps++;
            end
        end
        check("idle_ps_first", first_ps, PERIOD - 1);
        check("idle_ps_count", n_ps, 3);
        check("idle_pwm_high_cycles", acc, 0);

        // Table: one write, then the next full period shows duty*DVSR highs.
        for (int i = 0; i < 6; i++) begin
            wait_ps();
            cfg_write(tbl[i].ch, tbl[i].mode, tbl[i].duty);
            measure(tbl[i].ch, 1, 1'b0, hs);
            check($sformatf("table%0d_ch%0d_highs", i, tbl[i].ch), hs[0], tbl[i].exp_highs);
        end

        // TRI from 14: endpoints held for one step each.
        tri_exp[0] = 14; tri_exp[1] = 15; tri_exp[2] = 15;
        for (int j = 0; j < 15; j++) tri_exp[3 + j] = 14 - j;
        tri_exp[18] = 0; tri_exp[19] = 1;
        wait_ps();
        cfg_write(1, 3, 14);
        measure(1, 20, 1'b0, hs);
        for (int j = 0; j < 20; j++)
            check($sformatf("tri_period%0d_highs", j), hs[j], DVSR * tri_exp[j]);

        // SAW from 15 wraps to 0.
        wait_ps();
        cfg_write(2, 2, 15);
        measure(2, 3, 1'b0, hs);
        check("saw_p0_highs", hs[0], DVSR * 15);
        check("saw_p1_wrap_highs", hs[1], 0);
        check("saw_p2_highs", hs[2], DVSR * 1);

        // Write landing in the boundary cycle commits one period late.
        wait_ps();
        cfg_write(0, 1, 5);
        wait_ps();
        repeat (PERIOD - 1) @(negedge clk);
        cfg_write(0, 1, 9);
        check("bnd_write_period_start", int'(period_start), 1);
        measure(0, 2, 1'b1, hs);
        check("bnd_write_old_duty", hs[0], DVSR * 5);
        check("bnd_write_new_duty", hs[1], DVSR * 9);

        // Out-of-range channel write is ignored.
        wait_ps();
        cfg_write(3, 1, 7);
        measure(0, 1, 1'b0, hs);
        check("bad_ch_ch0_highs", hs[0], DVSR * 9);

        // Reset mid-period: low next cycle and nothing resumes.
        wait_ps();
        repeat (4) @(negedge clk);
        check("pre_rst_ch0", int'(pwm_out[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_period_start", int'(period_start), 0);
        rst = 1'b0;
        acc = 0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(negedge clk);
            acc += int'(pwm_out != '0);
        end
        check("post_rst_idle_highs", acc, 0);

        // Random config traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rst    = ($urandom_range(499) == 0);
            cfg_we = ($urandom_range(7) == 0);
            cfg_ch   = 2'($urandom_range(3));
            cfg_mode = 2'($urandom_range(3));
            cfg_duty = R'($urandom_range(LEVELS - 1));
            @(negedge clk);
        end
        rst = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
